mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller for the RV32I five-stage pipeline. It shares one byte-wide synchronous RAM port between instruction fetch (IF) and the data-access stage (MEM). It serialises each 32-bit access into byte transfers and assembles read bytes little-endian. It drives the stall requests that freeze the pipeline while an access is in flight.

## Interface
Parameters:
- ADDR_W, 17, RAM address width; upper request-address bits are discarded.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  taken-branch redirect; aborts an in-flight fetch
- if_req_i  in  1  fetch request; held high until if_done_o
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched instruction
- if_done_o  out  1  one-cycle pulse; if_data_o valid
- if_stall_o  out  1  if_req_i & ~if_done_o
- mem_req_i  in  1  data request; held high until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- mem_addr_i  in  32  data byte address
- mem_wdata_i  in  32  store data; byte k = bits [8k+7:8k]
- mem_data_o  out  32  load data, zero-extended
- mem_done_o  out  1  one-cycle pulse; access complete
- mem_stall_o  out  1  mem_req_i & ~mem_done_o
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write data
- ram_din_i  in  8  RAM read data, valid one cycle after its address

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Arbitration happens in IDLE only:
  - If mem_req_i is high: go to MEM_WR if mem_we_i, else MEM_RD. MEM wins over IF.
  - Else if if_req_i is high and flush_i is low: go to IF_RD.
- Preemption: none, except flush.
- On grant, latch the following: base address (low ADDR_W bits), byte count N (1/2/4; IF always 4), write data, requester ID.
- Byte k uses address base+k, modulo 2^ADDR_W. Wrap-around is legal. Misaligned addresses are legal; no trap is raised.
- MEM_WR:
  - Issue byte k on cycle k of the state, with ram_wr_o=1 and ram_dout_o = wdata byte k.
  - After N cycles go to DONE.
- IF_RD / MEM_RD:
  - Issue address k on cycle k.
  - Capture ram_din_i on cycle k+1 into result byte k.
  - After N+1 cycles go to DONE.
- Result buffer:
  - Cleared to 0 at grant, so half and byte loads are zero-extended.
  - Sign extension is done downstream.
- DONE, one cycle:
  - Pulse the granted requester's done.
  - Go to IDLE; requests are not sampled in DONE.
  - The requester may drop or retarget req on the done cycle.
- if_data_o / mem_data_o update only on the cycle their done asserts. They hold until that requester's next done.
- Flush:
  - flush_i high in IF_RD: go to IDLE next edge, with no if_done_o and if_data_o unchanged. Any in-flight ram_din_i is ignored.
  - flush_i in MEM_* or DONE: ignored.
  - flush_i in IDLE: blocks an IF grant that cycle only.
- ram_addr_o holds its last value when idle; ram_wr_o is 0 outside MEM_WR.

## Timing
- Grant edge = the edge at which IDLE samples a request (call it cycle 0); the first RAM address appears in cycle 1.
- done pulse cycle, measured from cycle 0:
  - Word read: 6
  - Half read: 4
  - Byte read: 3
  - Word write: 5
  - Half write: 3
  - Byte write: 2
- Back-to-back requests: the next grant is sampled in the IDLE cycle after DONE, so the minimum period is latency+1.
- Stall outputs are combinational from req inputs and registered done; there is no RAM→stall path.
- Reset values:
  - State IDLE.
  - All done outputs 0.
  - ram_wr_o 0, ram_addr_o 0, ram_dout_o 0.
  - if_data_o 0, mem_data_o 0.
- Reset mid-access: abandon immediately; no done; a partial store stays in RAM.
- Simultaneous IF and MEM request in IDLE: MEM is granted. IF stays stalled and is granted in the IDLE following MEM's DONE, if still requested.

## Structure
- Shared package entries:
  - FSM state encoding
  - Size codes MEM_SIZE_B/H/W
  - Constant EXE_MEM_BYTES(size) mapping size to 1/2/4
- Single module; no sub-module. The byte-assembly shift register is small enough to stay inline.

## Test plan
- Word fetch: RAM[0x100..0x103]=13,05,10,00; IF req at 0x100 → if_done_o at cycle 6 with if_data_o=0x00100513; ram_wr_o never high.
- Byte store: MEM store, size 0, addr 0x2003, wdata 0xAABBCCDD → one write of 0xDD at 0x2003; mem_done_o at cycle 2; other bytes unchanged.
- Half load with wrap: ADDR_W=17, addr 0x1FFFF, RAM[0x1FFFF]=0x34, RAM[0]=0x12 → mem_data_o=0x00001234 at cycle 4.
- Contention: IF and MEM store-word requested together → MEM done at cycle 5; IF granted at cycle 6, done at cycle 12; if_stall_o high cycles 0–11.
- Flush: flush_i pulsed at cycle 3 of a fetch → IDLE at cycle 4, no if_done_o, if_data_o unchanged; a new fetch requested at cycle 4 completes normally.
- Reset: rst asserted at cycle 2 of a word store → ram_wr_o=0 and all outputs at reset values from the next edge; only bytes 0–1 were written.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RV32I memory controller: FSM states, access sizes
// and the size-to-byte-count mapping used at grant time.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      IF_RD  = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   // Size code 3 is not a legal RV32I width; it is treated as a word.
   function automatic logic [2:0] EXE_MEM_BYTES(input logic [1:0] size);
      case (size)
         MEM_SIZE_B: EXE_MEM_BYTES = 3'd1;
         MEM_SIZE_H: EXE_MEM_BYTES = 3'd2;
         default:    EXE_MEM_BYTES = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one byte-wide synchronous RAM port between fetch and data access,
// serialising 32-bit accesses into byte transfers (little-endian).
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   output logic              if_stall_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_size_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_data_o,
   output logic              mem_done_o,
   output logic              mem_stall_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   state_t            state;
   logic [2:0]        cnt;
   logic [2:0]        nbytes;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic              is_if;
   logic [31:0]       rbuf;

   logic [2:0]        next;
   logic [1:0]        cap_idx;
   logic [31:0]       buf_upd;

   logic unused_addr_hi;
   assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

   assign if_stall_o  = if_req_i & ~if_done_o;
   assign mem_stall_o = mem_req_i & ~mem_done_o;

   // RAM data seen in state cycle cnt belongs to the address issued in cnt-1.
   always_comb begin
      next    = cnt + 3'd1;
      cap_idx = cnt[1:0] - 2'd1;
      buf_upd = rbuf;
      buf_upd[{cap_idx, 3'b000} +: 8] = ram_din_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         nbytes     <= '0;
         base       <= '0;
         wdata      <= '0;
         is_if      <= 1'b0;
         rbuf       <= '0;
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         if_data_o  <= '0;
         mem_data_o <= '0;
         ram_addr_o <= '0;
         ram_wr_o   <= 1'b0;
         ram_dout_o <= '0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  state      <= mem_we_i ? MEM_WR : MEM_RD;
                  base       <= mem_addr_i[ADDR_W-1:0];
                  nbytes     <= EXE_MEM_BYTES(mem_size_i);
                  wdata      <= mem_wdata_i;
                  is_if      <= 1'b0;
                  rbuf       <= '0;
                  cnt        <= '0;
                  ram_addr_o <= mem_addr_i[ADDR_W-1:0];
                  ram_wr_o   <= mem_we_i;
                  ram_dout_o <= mem_wdata_i[7:0];
               end else if (if_req_i && !flush_i) begin
                  state      <= IF_RD;
                  base       <= if_addr_i[ADDR_W-1:0];
                  nbytes     <= 3'd4;
                  is_if      <= 1'b1;
                  rbuf       <= '0;
                  cnt        <= '0;
                  ram_addr_o <= if_addr_i[ADDR_W-1:0];
               end
            end
            MEM_WR: begin
               if (next < nbytes) begin
                  cnt        <= next;
                  ram_addr_o <= base + ADDR_W'(next);
                  ram_dout_o <= wdata[{next[1:0], 3'b000} +: 8];
               end else begin
                  ram_wr_o   <= 1'b0;
                  state      <= DONE;
                  mem_done_o <= 1'b1;
               end
            end
            IF_RD, MEM_RD: begin
               if (state == IF_RD && flush_i) begin
                  state <= IDLE;
               end else begin
                  if (cnt != 3'd0)
                     rbuf <= buf_upd;
                  if (cnt == nbytes) begin
                     state <= DONE;
                     if (is_if) begin
                        if_done_o <= 1'b1;
                        if_data_o <= buf_upd;
                     end else begin
                        mem_done_o <= 1'b1;
                        mem_data_o <= buf_upd;
                     end
                  end else begin
                     cnt <= next;
                     if (next < nbytes)
                        ram_addr_o <= base + ADDR_W'(next);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl with a behavioural byte RAM (1-cycle read).
module tb_mem_ctrl;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          if_req;
   logic [31:0]   if_addr;
   logic [31:0]   if_data;
   logic          if_done;
   logic          if_stall;
   logic          mem_req;
   logic          mem_we;
   logic [1:0]    mem_size;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_data;
   logic          mem_done;
   logic          mem_stall;
   logic [AW-1:0] ram_addr;
   logic          ram_wr;
   logic [7:0]    ram_dout;
   logic [7:0]    ram_din;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data),
      .if_done_o(if_done), .if_stall_o(if_stall),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
      .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_data_o(mem_data),
      .mem_done_o(mem_done), .mem_stall_o(mem_stall),
      .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout),
      .ram_din_i(ram_din)
   );

   // RAM model; backdoor preload shares the write process.
   logic [7:0]    ram [0:(1<<AW)-1];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [7:0]    bd_data = '0;
   int            wr_cnt = 0;

   always @(posedge clk) begin
      ram_din <= ram[ram_addr];
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (ram_wr) begin
         ram[ram_addr] <= ram_dout;
         wr_cnt <= wr_cnt + 1;
      end
   end

   typedef struct {
      bit          is_if;
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Called at the negedge where the request was driven (cycle 0); returns
   // the cycle of the requested done, or -1 if it never comes.
   task automatic wait_done(input bit is_if, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(posedge clk); n++;
         @(negedge clk);
         seen = is_if ? if_done : mem_done;
      end
      if (!seen) n = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 0; if_req = 0; if_addr = 0; mem_req = 0;
      mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
      repeat (3) @(negedge clk);
      checks += 8;
      if (if_done !== 1'b0)  begin errors++; $display("FAIL rst_if_done got %0b want 0", if_done); end
      if (mem_done !== 1'b0) begin errors++; $display("FAIL rst_mem_done got %0b want 0", mem_done); end
      if (ram_wr !== 1'b0)   begin errors++; $display("FAIL rst_ram_wr got %0b want 0", ram_wr); end
      if (ram_addr !== '0)   begin errors++; $display("FAIL rst_ram_addr got %h want 0", ram_addr); end
      if (ram_dout !== 8'h0) begin errors++; $display("FAIL rst_ram_dout got %h want 0", ram_dout); end
      if (if_data !== 32'h0) begin errors++; $display("FAIL rst_if_data got %h want 0", if_data); end
      if (mem_data !== 32'h0) begin errors++; $display("FAIL rst_mem_data got %h want 0", mem_data); end
      if ({if_stall, mem_stall} !== 2'b00) begin errors++; $display("FAIL rst_stall got %b want 00", {if_stall, mem_stall}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch_word;
      int n, w0; exp_t e;
      poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h10); poke(17'h103, 8'h00);
      w0 = wr_cnt;
      sbq.push_back('{1'b1, 32'h0010_0513, 6});
      if_req = 1; if_addr = 32'h100;
      wait_done(1'b1, n);
      if_req = 0;
      e = sbq.pop_front();
      checks += 3;
      if (n !== e.cyc)      begin errors++; $display("FAIL fetch_cycle got %0d want %0d", n, e.cyc); end
      if (if_data !== e.data) begin errors++; $display("FAIL fetch_data got %h want %h", if_data, e.data); end
      if (wr_cnt - w0 !== 0)  begin errors++; $display("FAIL fetch_no_write got %0d writes want 0", wr_cnt - w0); end
      @(negedge clk);
      checks += 2;
      if (if_done !== 1'b0)   begin errors++; $display("FAIL fetch_done_pulse got %0b want 0", if_done); end
      if (if_data !== e.data) begin errors++; $display("FAIL fetch_data_hold got %h want %h", if_data, e.data); end
   endtask

   task automatic test_byte_store;
      int n, w0; exp_t e;
      for (int i = 0; i < 8; i++) poke(17'h2000 + AW'(i), 8'h10 + 8'(i));
      w0 = wr_cnt;
      sbq.push_back('{1'b0, 32'h0, 2});
      mem_req = 1; mem_we = 1; mem_size = 2'd0; mem_addr = 32'h2003; mem_wdata = 32'hAABB_CCDD;
      wait_done(1'b0, n);
      mem_req = 0; mem_we = 0;
      e = sbq.pop_front();
      checks += 5;
      if (n !== e.cyc)          begin errors++; $display("FAIL bstore_cycle got %0d want %0d", n, e.cyc); end
      if (ram[17'h2003] !== 8'hDD) begin errors++; $display("FAIL bstore_byte got %h want dd", ram[17'h2003]); end
      if (ram[17'h2002] !== 8'h12) begin errors++; $display("FAIL bstore_below got %h want 12", ram[17'h2002]); end
      if (ram[17'h2004] !== 8'h14) begin errors++; $display("FAIL bstore_above got %h want 14", ram[17'h2004]); end
      if (wr_cnt - w0 !== 1)       begin errors++; $display("FAIL bstore_writes got %0d want 1", wr_cnt - w0); end
      @(negedge clk);
   endtask

   task automatic test_loads;
      int n; exp_t e;
      // half load wrapping from the top of RAM to address 0
      poke(17'h1FFFF, 8'h34); poke(17'h0, 8'h12);
      sbq.push_back('{1'b0, 32'h0000_1234, 4});
      mem_req = 1; mem_we = 0; mem_size = 2'd1; mem_addr = 32'h0001_FFFF;
      wait_done(1'b0, n);
      mem_req = 0;
      e = sbq.pop_front();
      checks += 2;
      if (n !== e.cyc)         begin errors++; $display("FAIL hload_cycle got %0d want %0d", n, e.cyc); end
      if (mem_data !== e.data) begin errors++; $display("FAIL hload_data got %h want %h", mem_data, e.data); end
      @(negedge clk);
      // byte load, upper address bits discarded, zero-extended
      poke(17'h5, 8'hF7);
      sbq.push_back('{1'b0, 32'h0000_00F7, 3});
      mem_req = 1; mem_size = 2'd0; mem_addr = 32'h8002_0005;
      wait_done(1'b0, n);
      mem_req = 0;
      e = sbq.pop_front();
      checks += 2;
      if (n !== e.cyc)         begin errors++; $display("FAIL bload_cycle got %0d want %0d", n, e.cyc); end
      if (mem_data !== e.data) begin errors++; $display("FAIL bload_data got %h want %h", mem_data, e.data); end
      @(negedge clk);
      // misaligned word load, size code 3 treated as word
      poke(17'h6, 8'h01); poke(17'h7, 8'h23); poke(17'h8, 8'h45); poke(17'h9, 8'h67);
      sbq.push_back('{1'b0, 32'h6745_2301, 6});
      mem_req = 1; mem_size = 2'd3; mem_addr = 32'h6;
      wait_done(1'b0, n);
      mem_req = 0;
      e = sbq.pop_front();
      checks += 2;
      if (n !== e.cyc)         begin errors++; $display("FAIL wload_cycle got %0d want %0d", n, e.cyc); end
      if (mem_data !== e.data) begin errors++; $display("FAIL wload_data got %h want %h", mem_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n1, n2; exp_t e;
      poke(17'h10, 8'hA1); poke(17'h11, 8'hB2);
      sbq.push_back('{1'b0, 32'h0000_00A1, 3});
      sbq.push_back('{1'b0, 32'h0000_00B2, 7});
      mem_req = 1; mem_we = 0; mem_size = 2'd0; mem_addr = 32'h10;
      wait_done(1'b0, n1);
      mem_addr = 32'h11;
      e = sbq.pop_front();
      checks += 2;
      if (n1 !== e.cyc)        begin errors++; $display("FAIL b2b_first_cycle got %0d want %0d", n1, e.cyc); end
      if (mem_data !== e.data) begin errors++; $display("FAIL b2b_first_data got %h want %h", mem_data, e.data); end
      wait_done(1'b0, n2);
      mem_req = 0;
      e = sbq.pop_front();
      checks += 2;
      if (n1 + n2 !== e.cyc)   begin errors++; $display("FAIL b2b_second_cycle got %0d want %0d", n1 + n2, e.cyc); end
      if (mem_data !== e.data) begin errors++; $display("FAIL b2b_second_data got %h want %h", mem_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_contention;
      int n, mem_n, if_n; bit stall_ok; exp_t em, ei;
      poke(17'h300, 8'h93); poke(17'h301, 8'h02); poke(17'h302, 8'h00); poke(17'h303, 8'h00);
      for (int i = 0; i < 4; i++) poke(17'h400 + AW'(i), 8'h00);
      sbq.push_back('{1'b0, 32'h0, 5});
      sbq.push_back('{1'b1, 32'h0000_0293, 12});
      mem_req = 1; mem_we = 1; mem_size = 2'd2; mem_addr = 32'h400; mem_wdata = 32'h1122_3344;
      if_req = 1; if_addr = 32'h300;
      #1;
      stall_ok = (if_stall === 1'b1);
      n = 0; mem_n = -1; if_n = -1;
      while (if_n < 0 && n < 40) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (n <= 11 && if_stall !== 1'b1) stall_ok = 1'b0;
         if (mem_done) begin mem_n = n; mem_req = 0; mem_we = 0; end
         if (if_done) begin
            if_n = n;
            if (if_stall !== 1'b0) stall_ok = 1'b0;
            if_req = 0;
         end
      end
      em = sbq.pop_front();
      ei = sbq.pop_front();
      checks += 5;
      if (mem_n !== em.cyc)   begin errors++; $display("FAIL cont_mem_cycle got %0d want %0d", mem_n, em.cyc); end
      if (if_n !== ei.cyc)    begin errors++; $display("FAIL cont_if_cycle got %0d want %0d", if_n, ei.cyc); end
      if (if_data !== ei.data) begin errors++; $display("FAIL cont_if_data got %h want %h", if_data, ei.data); end
      if (stall_ok !== 1'b1)  begin errors++; $display("FAIL cont_if_stall got irregular want high 0-11"); end
      if ({ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]} !== 32'h1122_3344)
         begin errors++; $display("FAIL cont_store got %h want 11223344", {ram[17'h403], ram[17'h402], ram[17'h401], ram[17'h400]}); end
      @(negedge clk);
   endtask

   task automatic test_flush;
      int n; bit early; logic [31:0] d4; exp_t e;
      sbq.push_back('{1'b1, 32'h0010_0513, 10});
      if_req = 1; if_addr = 32'h100;
      n = 0; early = 1'b0; d4 = '0;
      while (n < 40) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (if_done) break;
         if (n == 3) flush = 1'b1;
         if (n == 4) begin flush = 1'b0; d4 = if_data; end
      end
      if_req = 0;
      if (n < 10) early = 1'b1;
      e = sbq.pop_front();
      checks += 4;
      if (early !== 1'b0)       begin errors++; $display("FAIL flush_early_done got cycle %0d want none before 10", n); end
      if (d4 !== 32'h0000_0293) begin errors++; $display("FAIL flush_data_hold got %h want 00000293", d4); end
      if (n !== e.cyc)          begin errors++; $display("FAIL flush_refetch_cycle got %0d want %0d", n, e.cyc); end
      if (if_data !== e.data)   begin errors++; $display("FAIL flush_refetch_data got %h want %h", if_data, e.data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_store;
      bit done_seen;
      for (int i = 0; i < 4; i++) poke(17'h500 + AW'(i), 8'h55);
      mem_req = 1; mem_we = 1; mem_size = 2'd2; mem_addr = 32'h500; mem_wdata = 32'hDEAD_BEEF;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1; mem_req = 0; mem_we = 0;
      @(posedge clk); @(negedge clk);
      checks += 5;
      if (ram_wr !== 1'b0)   begin errors++; $display("FAIL rmid_ram_wr got %0b want 0", ram_wr); end
      if (ram_addr !== '0)   begin errors++; $display("FAIL rmid_ram_addr got %h want 0", ram_addr); end
      if (ram_dout !== 8'h0) begin errors++; $display("FAIL rmid_ram_dout got %h want 0", ram_dout); end
      if ({if_data, mem_data} !== 64'h0) begin errors++; $display("FAIL rmid_data got %h want 0", {if_data, mem_data}); end
      if (mem_done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0b want 0", mem_done); end
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (6) begin @(posedge clk); @(negedge clk); if (mem_done) done_seen = 1'b1; end
      checks += 2;
      if (done_seen !== 1'b0) begin errors++; $display("FAIL rmid_late_done got 1 want 0"); end
      if ({ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]} !== 32'h5555_BEEF)
         begin errors++; $display("FAIL rmid_partial got %h want 5555beef", {ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]}); end
   endtask

   initial begin
      test_reset();
      test_fetch_word();
      test_byte_store();
      test_loads();
      test_back_to_back();
      test_contention();
      test_flush();
      test_reset_mid_store();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
